// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - two requester ports plus shared RAM port of the arbiter
interface ram_port_arbiter_if;
  // requester 0 (bios)
  logic        p0_req;
  logic        p0_we;
  logic [3:0]  p0_be;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  // requester 1 (core)
  logic        p1_req;
  logic        p1_we;
  logic [3:0]  p1_be;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  // shared read return
  logic [31:0] rdata;
  // RAM side
  logic        ram_read_req;
  logic [31:0] ram_read_addr;
  logic        ram_write_enable;
  logic [3:0]  ram_byte_enable;
  logic [31:0] ram_write_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  // arbiter side
  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    input  ram_read_data,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    output ram_read_req, ram_read_addr,
    output ram_write_enable, ram_byte_enable, ram_write_addr, ram_write_data
  );

  // requesters and RAM side
  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    output ram_read_data,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    input  ram_read_req, ram_read_addr,
    input  ram_write_enable, ram_byte_enable, ram_write_addr, ram_write_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port single-RAM arbiter with burst-limited ownership
module ram_port_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  ram_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_C = 8'(MAX_BURST);

  state_t      state_q, state_d;
  state_t      owner_c;
  logic [7:0]  burst_q, burst_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;

  logic        en_c;
  logic        pick1_c;
  logic        gnt0_c, gnt1_c;

  logic        rd_req_c;
  logic [31:0] rd_addr_c;
  logic        wr_en_c;
  logic [3:0]  wr_be_c;
  logic [31:0] wr_addr_c;
  logic [31:0] wr_data_c;

  // Arbitration: pick1_c selects port 1 when it is the sole requester or wins a contest
  always_comb begin
    en_c    = clk_en & ~rst;
    pick1_c = 1'b0;
    if (bus.p1_req && !bus.p0_req) begin
      pick1_c = 1'b1;
    end else if (bus.p0_req && bus.p1_req) begin
      case (state_q)
        OWN0:    pick1_c = (burst_q >= MAX_C);
        OWN1:    pick1_c = (burst_q <  MAX_C);
        default: pick1_c = 1'b0;
      endcase
    end
    gnt0_c = en_c & bus.p0_req & ~pick1_c;
    gnt1_c = en_c & bus.p1_req &  pick1_c;
  end

  // Route the granted port's request onto the RAM port; everything zero otherwise
  always_comb begin
    rd_req_c  = 1'b0;
    rd_addr_c = 32'h0;
    wr_en_c   = 1'b0;
    wr_be_c   = 4'h0;
    wr_addr_c = 32'h0;
    wr_data_c = 32'h0;
    if (gnt0_c) begin
      if (bus.p0_we) begin
        wr_en_c   = 1'b1;
        wr_be_c   = bus.p0_be;
        wr_addr_c = bus.p0_addr;
        wr_data_c = bus.p0_wdata;
      end else begin
        rd_req_c  = 1'b1;
        rd_addr_c = bus.p0_addr;
      end
    end else if (gnt1_c) begin
      if (bus.p1_we) begin
        wr_en_c   = 1'b1;
        wr_be_c   = bus.p1_be;
        wr_addr_c = bus.p1_addr;
        wr_data_c = bus.p1_wdata;
      end else begin
        rd_req_c  = 1'b1;
        rd_addr_c = bus.p1_addr;
      end
    end
  end

  // Next ownership, burst length and read-valid; everything holds while clk_en is low
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    rvalid0_d = rvalid0_q;
    rvalid1_d = rvalid1_q;
    owner_c   = gnt1_c ? OWN1 : OWN0;
    if (clk_en) begin
      rvalid0_d = gnt0_c & ~bus.p0_we;
      rvalid1_d = gnt1_c & ~bus.p1_we;
      if (gnt0_c || gnt1_c) begin
        if (state_q == owner_c) begin
          // saturate so a long solo burst never overflows the 8-bit count
          burst_d = (burst_q >= MAX_C) ? MAX_C : burst_q + 8'd1;
        end else begin
          state_d = owner_c;
          burst_d = 8'd1;
        end
      end else begin
        state_d = IDLE;
        burst_d = 8'd0;
      end
    end
  end

  // Arbiter state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      burst_q   <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign bus.p0_gnt           = gnt0_c;
  assign bus.p1_gnt           = gnt1_c;
  assign bus.p0_rvalid        = rvalid0_q;
  assign bus.p1_rvalid        = rvalid1_q;
  assign bus.rdata            = bus.ram_read_data;
  assign bus.ram_read_req     = rd_req_c;
  assign bus.ram_read_addr    = rd_addr_c;
  assign bus.ram_write_enable = wr_en_c;
  assign bus.ram_byte_enable  = wr_be_c;
  assign bus.ram_write_addr   = wr_addr_c;
  assign bus.ram_write_data   = wr_data_c;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  ram_port_arbiter_if bus();

  ram_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        rv0;
    logic        rv1;
    logic [31:0] rdata;
    logic        rreq;
    logic [31:0] raddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0111);
  endfunction

  // Behavioural RAM: registered read, byte-enabled write, advances on enabled edges
  logic [31:0] ram_mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
    end else if (clk_en) begin
      if (bus.ram_read_req) bus.ram_read_data <= ram_mem[bus.ram_read_addr[5:2]];
      if (bus.ram_write_enable)
        for (int b = 0; b < 4; b++)
          if (bus.ram_byte_enable[b])
            ram_mem[bus.ram_write_addr[5:2]][8*b +: 8] <= bus.ram_write_data[8*b +: 8];
    end
  end

  // Reference model: who owns the RAM, how long the current run is, what reads return
  logic [31:0] ref_mem [16];
  int          owner;
  int          run;
  logic        rv0, rv1;
  logic [31:0] rvd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expected record per cycle and compares mid-cycle
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("gnt", {126'd0, bus.p0_gnt, bus.p1_gnt}, {126'd0, x.g0, x.g1});
      chk("ram_port",
          {26'd0, bus.ram_read_req, bus.ram_read_addr, bus.ram_write_enable,
           bus.ram_byte_enable, bus.ram_write_addr, bus.ram_write_data},
          {26'd0, x.rreq, x.raddr, x.we, x.be, x.waddr, x.wdata});
      chk("rvalid", {126'd0, bus.p0_rvalid, bus.p1_rvalid}, {126'd0, x.rv0, x.rv1});
      if (x.rv0 || x.rv1) chk("rdata", {96'd0, bus.rdata}, {96'd0, x.rdata});
    end
  end

  task automatic set_p0(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    bus.p0_req = r; bus.p0_we = w; bus.p0_be = b; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    bus.p1_req = r; bus.p1_we = w; bus.p1_be = b; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  // Apply rst/clk_en for one cycle, queue the expected response, advance the model
  task automatic step(input logic r, input logic e);
    exp_t        x;
    int          win;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a, d;
    rst    = r;
    clk_en = e;
    if (r) begin
      owner = -1; run = 0; rv0 = 1'b0; rv1 = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end
    win = -1;
    if (!r && e) begin
      if (bus.p0_req && bus.p1_req) win = (owner < 0) ? 0 : ((run < MAXB) ? owner : 1 - owner);
      else if (bus.p0_req) win = 0;
      else if (bus.p1_req) win = 1;
    end
    we = (win == 0) ? bus.p0_we    : bus.p1_we;
    be = (win == 0) ? bus.p0_be    : bus.p1_be;
    a  = (win == 0) ? bus.p0_addr  : bus.p1_addr;
    d  = (win == 0) ? bus.p0_wdata : bus.p1_wdata;
    x = '0;
    x.g0 = (win == 0); x.g1 = (win == 1);
    x.rv0 = rv0; x.rv1 = rv1; x.rdata = rvd;
    if (win >= 0) begin
      if (we) begin x.we = 1'b1; x.be = be; x.waddr = a; x.wdata = d; end
      else    begin x.rreq = 1'b1; x.raddr = a; end
    end
    exp_q.push_back(x);
    if (!r && e) begin
      rv0 = (win == 0) && !we;
      rv1 = (win == 1) && !we;
      if (win >= 0 && !we) rvd = ref_mem[a[5:2]];
      if (win >= 0 && we)
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      if (win < 0)           begin owner = -1; run = 0; end
      else if (win == owner) run = (run < MAXB) ? run + 1 : MAXB;
      else                   begin owner = win; run = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    owner = -1; run = 0; rv0 = 1'b0; rv1 = 1'b0; rvd = 32'h0;
    rst = 1'b1; clk_en = 1'b0;
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // reset holds everything low even with requests present
    set_p0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // single p0 read at 0x10, then idle to see rvalid and rdata
    step(1'b0, 1'b1);
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // both ports requesting continuously: 8/8 alternation
    set_p0(1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

    // p1 write while p0 idle, then read it back
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b1, 4'h3, 32'h20, 32'hDEADBEEF);
    step(1'b0, 1'b1);
    set_p1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step(1'b0, 1'b1);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1);

    // clk_en toggling 1,0,1 during a p1 read
    set_p1(1'b1, 1'b0, 4'h0, 32'h2C, 32'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // reset in the middle of a p1 burst, then both request after release
    set_p1(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    set_p0(1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // p1 alone long enough to saturate, then p0 joins
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    set_p0(1'b1, 1'b1, 4'hF, 32'h38, 32'h12345678);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // randomized traffic with occasional clk_en drops and resets
    for (int i = 0; i < 500; i++) begin
      set_p0(($urandom_range(0, 9) < 6), 1'($urandom), 4'($urandom),
             $urandom & 32'hFFFF_FFFC, $urandom);
      set_p1(($urandom_range(0, 9) < 6), 1'($urandom), 4'($urandom),
             $urandom & 32'hFFFF_FFFC, $urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8));
    end

    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8: max consecutive grants to one port while the other port requests; legal range 1..255.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. The ports are clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 clk_en  in  1  cycle enable; state advances only on edges where clk_en=1.
REQ-006 pN_req  in  1  (N=0 bios, N=1 core) access request; level, held until granted.
REQ-007 pN_we  in  1  1=write, 0=read.
REQ-008 pN_be  in  4  write byte enables.
REQ-009 pN_addr  in  32  byte address.
REQ-010 pN_wdata  in  32  write data.
REQ-011 pN_gnt  out  1  request accepted this cycle.
REQ-012 pN_rvalid  out  1  read data valid on rdata.
REQ-013 rdata  out  32  shared read return, equal to ram_read_data.
REQ-014 ram_read_req / ram_read_addr[32]  out  RAM read strobe and address.
REQ-015 ram_write_enable / ram_byte_enable[4] / ram_write_addr[32] / ram_write_data[32]  out  RAM write port.
REQ-016 ram_read_data  in  32  RAM registered read data, valid one enabled cycle after read_req.

Function
REQ-017 At most one pN_gnt SHALL be high in any cycle; gnt is combinational from req, state and clk_en.
REQ-018 If clk_en=0 or rst=1, no gnt is issued and all ram_* strobes are 0.
REQ-019 The granted port's we/be/addr/wdata SHALL drive the RAM port combinationally in the grant cycle:
- read: ram_read_req=1, ram_read_addr=addr.
- write: ram_write_enable=1, ram_byte_enable=be, ram_write_addr=addr, ram_write_data=wdata.
REQ-020 With no grant, ram_read_req=0, ram_write_enable=0, ram_byte_enable=0 and all RAM address/data outputs are 0.
REQ-021 The state machine SHALL have states IDLE, OWN0 and OWN1, plus an 8-bit burst_cnt.
REQ-022 Arbitration SHALL follow these rules:
- Only one port requesting: that port wins.
- Both requesting from IDLE: port 0 wins.
- Both requesting in OWNx: x wins if burst_cnt<MAX_BURST, else the other port wins.
REQ-023 On an enabled edge, the state and counter SHALL update:
- Grant to the same owner: burst_cnt increments, saturating at MAX_BURST.
- Grant to a new owner: state becomes OWNy and burst_cnt becomes 1.
- No grant: state becomes IDLE and burst_cnt becomes 0.
REQ-024 A saturated burst_cnt with the other port idle SHALL NOT block the owner; the switch occurs on the first cycle the other port requests.
REQ-025 pN_rvalid SHALL be registered and set to 1 on the enabled edge after a granted read from port N, else 0; it is never high for writes.
REQ-026 When clk_en=0, state, burst_cnt and pN_rvalid SHALL hold their values.
REQ-027 Writes SHALL complete in the grant cycle; back-to-back grants (read then write, or either port) SHALL be allowed every enabled cycle.
REQ-028 A request deasserted before grant SHALL be dropped silently; requesters keep fields stable while req=1 and not granted.

Reset
REQ-029 While rst=1, the block SHALL hold asynchronously: state=IDLE, burst_cnt=0, p0_rvalid=p1_rvalid=0, both gnt=0, all ram_* outputs 0.
REQ-030 After rst deasserts, the first enabled cycle SHALL arbitrate from IDLE.
REQ-031 A read granted in the cycle rst asserts SHALL produce no rvalid.

Verification
REQ-032 p0 read addr 0x10 alone, clk_en=1: p0_gnt same cycle, ram_read_addr=0x10, p0_rvalid=1 next cycle with rdata=RAM word.
REQ-033 Both ports request continuously, MAX_BURST=8: grants alternate as 8 to p0, then 8 to p1, repeating; never both gnt.
REQ-034 p1 write be=0x3 data=0xDEADBEEF addr=0x20 while p0 idle: ram_write_enable=1, ram_byte_enable=0x3, ram_write_data=0xDEADBEEF; no rvalid.
REQ-035 clk_en toggles 1,0,1 during a p1 read: gnt only when clk_en=1; p1_rvalid holds through clk_en=0 and state is unchanged.
REQ-036 rst pulse mid-burst (burst_cnt=5, OWN1): all outputs 0 immediately; after release, simultaneous requests grant p0 first.
REQ-037 p1 alone for 20 cycles, then p0 requests: p0 is granted on its first request cycle (burst_cnt saturated at 8).
